// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the PWM duty-ramp controller.
package pwm_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RAMP = 1'b1
    } ramp_state_t;

    localparam int unsigned PWM_DUTY_W    = 4;
    localparam int unsigned PWM_DUTY_MAX  = 10;
    localparam int unsigned PWM_DUTY_INIT = 5;

endpackage

// File: rtl/pwm_ramp_tick.sv
// Divides PWM period boundaries by RAMP_DIV; step_c fires on the qualifying period_start.
module pwm_ramp_tick #(
    parameter int unsigned RAMP_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic period_start,
    output logic step_c
);

    localparam int unsigned TICK_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RAMP_DIV - 1);

    logic [TICK_W-1:0] tick;

    // Clear dominates so the count restarts from zero on every ramp entry.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            tick <= '0;
        end else if (period_start) begin
            tick <= (tick == TICK_LAST) ? '0 : tick + TICK_W'(1);
        end
    end

    assign step_c = period_start && (tick == TICK_LAST);

endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// Arbitrates host and button duty requests into a target and slews the applied
// duty toward it one step per RAMP_DIV PWM periods, only at period boundaries.
module pwm_duty_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int unsigned DUTY_W    = PWM_DUTY_W,
    parameter int unsigned DUTY_MAX  = PWM_DUTY_MAX,
    parameter int unsigned DUTY_INIT = PWM_DUTY_INIT,
    parameter int unsigned RAMP_DIV  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              period_start,
    input  logic              btn_inc,
    input  logic              btn_dec,
    input  logic              host_valid,
    input  logic [DUTY_W-1:0] host_duty,
    output logic              host_ready,
    output logic [DUTY_W-1:0] duty,
    output logic              busy
);

    localparam logic [DUTY_W-1:0] MAX_D  = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] INIT_D = DUTY_W'(DUTY_INIT);

    ramp_state_t       state;
    ramp_state_t       state_next;
    logic [DUTY_W-1:0] target;
    logic [DUTY_W-1:0] target_next;
    logic [DUTY_W-1:0] duty_next;
    logic              host_ready_next;
    logic              busy_next;
    logic              host_fire;
    logic              step_c;

    assign host_fire = host_valid && host_ready;

    pwm_ramp_tick #(
        .RAMP_DIV(RAMP_DIV)
    ) u_tick (
        .clk         (clk),
        .rst         (rst),
        .clear       (state == IDLE),
        .period_start(period_start),
        .step_c      (step_c)
    );

    // Next-state, target arbitration and duty slew.
    always_comb begin
        state_next      = state;
        target_next     = target;
        duty_next       = duty;
        host_ready_next = 1'b1;
        busy_next       = 1'b0;

        if (host_fire) begin
            target_next = (host_duty > MAX_D) ? MAX_D : host_duty;
        end else if (btn_inc && !btn_dec) begin
            target_next = (target >= MAX_D) ? MAX_D : target + DUTY_W'(1);
        end else if (btn_dec && !btn_inc) begin
            target_next = (target == '0) ? '0 : target - DUTY_W'(1);
        end

        case (state)
            IDLE: begin
                if (target != duty) begin
                    state_next = RAMP;
                end
            end
            RAMP: begin
                if (target == duty) begin
                    state_next = IDLE;
                end
                if (step_c) begin
                    if (target > duty) begin
                        duty_next = duty + DUTY_W'(1);
                    end else if (target < duty) begin
                        duty_next = duty - DUTY_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        host_ready_next = (state_next == IDLE);
        busy_next       = (state_next == RAMP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            target     <= INIT_D;
            duty       <= INIT_D;
            host_ready <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            target     <= target_next;
            duty       <= duty_next;
            host_ready <= host_ready_next;
            busy       <= busy_next;
        end
    end

endmodule

// File: doc/pwm_duty_ramp_ctrl.md
# pwm_duty_ramp_ctrl

Duty-cycle controller that sits in front of the PWM datapath and owns its duty register. Two requester classes write it: a host port with a valid/ready handshake, and the single-cycle debounced increment/decrement button pulses. Requests are arbitrated and set a target duty. The applied duty slews toward that target one step at a time, and only at PWM period boundaries, so the output never glitches mid-period.

## Interface
Parameters:
- DUTY_W, 4: width of duty values.
- DUTY_MAX, 10: PWM period length in counter steps and the maximum duty (duty == DUTY_MAX means 100 %).
- DUTY_INIT, 5: duty and target after reset (50 %).
- RAMP_DIV, 4: number of PWM periods per one-step duty change; must be ≥ 1.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- period_start  in  1  one-cycle pulse from the PWM counter on the cycle its counter wraps to 0.
- btn_inc  in  1  one-cycle debounced pulse requesting target + 1.
- btn_dec  in  1  one-cycle debounced pulse requesting target − 1.
- host_valid  in  1  host duty request valid.
- host_duty  in  DUTY_W  requested target duty.
- host_ready  out  1  host request can be accepted; transfer occurs when host_valid & host_ready.
- duty  out  DUTY_W  applied duty to the PWM comparator (registered).
- busy  out  1  ramp in progress.

## Operation
- Registers: target, duty, tick counter (0..RAMP_DIV−1), and state, which is IDLE or RAMP.
- Reset values: duty = target = DUTY_INIT, tick counter = 0, state = IDLE, busy = 0, host_ready = 1.
- host_ready = (state == IDLE). busy = (state == RAMP). Both are decoded from the state register.
- Arbitration, applied per cycle in priority order:
  - An accepted host transfer sets target = min(host_duty, DUTY_MAX). Any button pulse in the same cycle is dropped.
  - If no host transfer occurs, btn_inc and btn_dec asserted together cancel, and target is unchanged.
  - btn_inc alone: target + 1, saturating at DUTY_MAX.
  - btn_dec alone: target − 1, saturating at 0.
  - Buttons are honoured in both IDLE and RAMP. The host port is honoured only in IDLE.
- State transitions:
  - IDLE → RAMP when the registered target ≠ duty.
  - RAMP → IDLE when the registered target == duty.
  - The tick counter clears on entry to RAMP.
- In RAMP, on each period_start:
  - If tick == RAMP_DIV−1: duty moves one step toward the registered target and tick returns to 0.
  - Otherwise tick increments.
- period_start is ignored in IDLE.
- duty changes only on a cycle where period_start is high.
- Step direction uses the target value registered before the edge. A button edit during a ramp may reverse direction on the next step without resetting tick.

## Timing
- Host accept in cycle N: target is updated at the edge ending N. busy rises and host_ready falls at the edge ending N+1, if the new target ≠ duty.
- If the accepted target equals the current duty, state stays IDLE and host_ready stays 1.
- First duty step occurs on the RAMP_DIV-th period_start strictly after RAMP entry.
- Duty updates at the edge ending the qualifying period_start cycle, so the PWM's new period uses the new value.
- Last step: duty == target at edge E. busy falls and host_ready rises at edge E+1.
- A button edit that makes target == duty in RAMP returns the block to IDLE one cycle later. duty is not altered.
- rst high at any point, including mid-ramp: all registers take their reset values at that edge.
- Requests presented while rst is high are ignored.

## Structure
- Shared package pwm_pkg holds:
  - the state enum (IDLE, RAMP);
  - default constants PWM_DUTY_W = 4, PWM_DUTY_MAX = 10, PWM_DUTY_INIT = 5.
- One sub-module, pwm_ramp_tick: the RAMP_DIV period divider. It has clear and period_start inputs and a step-pulse output.
- Arbitration, target saturation, and the FSM live in the top module.

## Test plan
Common setup: RAMP_DIV = 2, period_start every 10 cycles.
- Reset: hold rst 2 cycles → duty = 5, busy = 0, host_ready = 1. No duty change over 5 periods.
- Host up-ramp: host_duty = 9 accepted → busy = 1 next cycle. duty steps 6, 7, 8, 9 on every 2nd period_start. busy = 0 and host_ready = 1 one cycle after duty = 9.
- Clamp/saturation:
  - host_duty = 15 → ramps to 10, then stops.
  - btn_inc at target 10 → target stays 10.
  - Host 0, then btn_dec → target stays 0.
- Simultaneous events:
  - btn_inc with btn_dec → target unchanged.
  - host_valid (duty 2) with btn_inc in IDLE at 5 → target = 2.
- Handshake: host_valid held with duty 3 during a ramp → host_ready = 0, no accept. Accepted on the first IDLE cycle, then duty ramps to 3.
- Reset mid-ramp: ramp 5 → 9 in progress at duty 7, assert rst → next cycle duty = 5, target = 5, busy = 0, tick = 0.
